// File: rtl/s832_bist_pkg.sv
// Shared types and constants for the s832 response compactor.
// Output-bit indices follow the s832 primary-output bus, MSB first.
package s832_bist_pkg;

    localparam int S832_OUT_W = 19;

    localparam logic [S832_OUT_W-1:0] S832_POLY_DEF = 19'h00027;
    localparam logic [S832_OUT_W-1:0] S832_SEED_DEF = 19'h00000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEED,
        ST_COMPACT,
        ST_COMPARE,
        ST_DONE
    } state_t;

    localparam int IDX_G327 = 18;
    localparam int IDX_G325 = 17;
    localparam int IDX_G300 = 16;
    localparam int IDX_G322 = 15;
    localparam int IDX_G45  = 14;
    localparam int IDX_G312 = 13;
    localparam int IDX_G53  = 12;
    localparam int IDX_G49  = 11;
    localparam int IDX_G47  = 10;
    localparam int IDX_G296 = 9;
    localparam int IDX_G290 = 8;
    localparam int IDX_G292 = 7;
    localparam int IDX_G298 = 6;
    localparam int IDX_G288 = 5;
    localparam int IDX_G315 = 4;
    localparam int IDX_G55  = 3;
    localparam int IDX_G43  = 2;
    localparam int IDX_G310 = 1;
    localparam int IDX_G302 = 0;

endpackage

// File: rtl/misr_core.sv
// Galois-feedback multiple-input signature register, datapath only.
// Latency: one cycle per enabled update; load has priority over enable.
// Backpressure: none; the caller gates en.
module misr_core #(
    parameter int                 WIDTH = 19,
    parameter logic [WIDTH-1:0]   POLY  = 19'h00027,
    parameter logic [WIDTH-1:0]   SEED  = 19'h00000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sig
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= {sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0) ^ din;
        end
    end

endmodule

// File: rtl/s832_resp_misr.sv
// s832 response compactor: MISR over pat_count responses, then golden compare.
// Latency: done/pass register on the edge after the COMPARE cycle.
// Backpressure: none; resp_valid gaps simply stall. Optional S832_MISR_XMASK_EN adds resp_mask.
module s832_resp_misr
    import s832_bist_pkg::*;
#(
    parameter int               WIDTH = S832_OUT_W,
    parameter logic [WIDTH-1:0] POLY  = S832_POLY_DEF,
    parameter logic [WIDTH-1:0] SEED  = S832_SEED_DEF,
    parameter int               CNT_W = 16
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             start,
    input  logic [CNT_W-1:0] pat_count,
    input  logic [WIDTH-1:0] resp,
    input  logic             resp_valid,
`ifdef S832_MISR_XMASK_EN
    input  logic [WIDTH-1:0] resp_mask,
`endif
    input  logic [WIDTH-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             accept;
    logic [WIDTH-1:0] din;

    assign load   = start && (state == ST_IDLE || state == ST_DONE);
    assign accept = resp_valid && (state == ST_COMPACT);

`ifdef S832_MISR_XMASK_EN
    assign din = resp & ~resp_mask;
`else
    assign din = resp;
`endif

    misr_core #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk   (CK),
        .rst_n (RN),
        .load  (load),
        .en    (accept),
        .din   (din),
        .sig   (signature)
    );

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_SEED;
                        cnt   <= pat_count;
                        pass  <= 1'b0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                ST_SEED: begin
                    state <= (cnt != '0) ? ST_COMPACT : ST_COMPARE;
                end
                ST_COMPACT: begin
                    if (resp_valid) begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= ST_COMPARE;
                        end
                    end
                end
                ST_COMPARE: begin
                    pass  <= (signature == golden);
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_s832_resp_misr.sv
// Directed bench for s832_resp_misr: table of runs plus reset/ignored-start sequences.
module tb_s832_resp_misr;

    localparam int W = 19;
    localparam logic [W-1:0] POLY = 19'h00027;

    logic          CK = 1'b0;
    logic          RN = 1'b0;
    logic          start = 1'b0;
    logic [15:0]   pat_count = '0;
    logic [W-1:0]  resp = '0;
    logic          resp_valid = 1'b0;
    logic [W-1:0]  resp_mask = '0;
    logic [W-1:0]  golden = '0;
    logic          busy, done, pass;
    logic [W-1:0]  signature;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 CK = ~CK;

    s832_resp_misr dut (
        .CK         (CK),
        .RN         (RN),
        .start      (start),
        .pat_count  (pat_count),
        .resp       (resp),
        .resp_valid (resp_valid),
`ifdef S832_MISR_XMASK_EN
        .resp_mask  (resp_mask),
`endif
        .golden     (golden),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature)
    );

    typedef struct packed {
        logic [15:0]        pc;
        logic [9:0][W-1:0]  r;
        logic [9:0][3:0]    gap;
        logic [W-1:0]       mask;
        logic [W-1:0]       golden;
        logic [W-1:0]       exp_sig;
        logic               exp_pass;
    } vec_t;

    vec_t tbl [7];
    int   n_vec;

    function automatic logic [W-1:0] step(input logic [W-1:0] s, input logic [W-1:0] d);
        return {s[W-2:0], 1'b0} ^ (s[W-1] ? POLY : '0) ^ d;
    endfunction

    function automatic logic [W-1:0] eff(input logic [W-1:0] d, input logic [W-1:0] m);
`ifdef S832_MISR_XMASK_EN
        return d & ~m;
`else
        return d | (m & '0);
`endif
    endfunction

    function automatic logic [W-1:0] model_sig(input vec_t v);
        logic [W-1:0] s;
        s = '0;
        for (int i = 0; i < int'(v.pc); i++) s = step(s, eff(v.r[i], v.mask));
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [W-1:0] m;
        m = '0;
        @(negedge CK);
        start = 1'b1; pat_count = v.pc; golden = v.golden; resp_mask = v.mask;
        @(negedge CK);
        start = 1'b0;
        chk($sformatf("v%0d busy_seed", idx), {31'd0, busy}, 32'd1);
        chk($sformatf("v%0d sig_seed", idx), {13'd0, signature}, 32'd0);
        resp = 19'h5A5A5; resp_valid = 1'b1;   // presented during SEED, must be ignored
        @(negedge CK);
        resp_valid = 1'b0;
        for (int i = 0; i < int'(v.pc); i++) begin
            for (int g = 0; g < int'(v.gap[i]); g++) begin
                @(negedge CK);
                chk($sformatf("v%0d busy_gap", idx), {31'd0, busy}, 32'd1);
            end
            resp = v.r[i]; resp_valid = 1'b1;
            @(negedge CK);
            resp_valid = 1'b0;
            m = step(m, eff(v.r[i], v.mask));
            chk($sformatf("v%0d sig_step%0d", idx, i), {13'd0, signature}, {13'd0, m});
        end
        chk($sformatf("v%0d done_early", idx), {31'd0, done}, 32'd0);
        chk($sformatf("v%0d busy_cmp", idx), {31'd0, busy}, 32'd1);
        resp = 19'h31337; resp_valid = 1'b1;   // beyond the final count
        @(negedge CK);
        chk($sformatf("v%0d done", idx), {31'd0, done}, 32'd1);
        chk($sformatf("v%0d busy_end", idx), {31'd0, busy}, 32'd0);
        chk($sformatf("v%0d pass", idx), {31'd0, pass}, {31'd0, v.exp_pass});
        chk($sformatf("v%0d sig_final", idx), {13'd0, signature}, {13'd0, v.exp_sig});
        @(negedge CK);
        resp_valid = 1'b0;
        chk($sformatf("v%0d sig_hold", idx), {13'd0, signature}, {13'd0, v.exp_sig});
        chk($sformatf("v%0d done_hold", idx), {31'd0, done}, 32'd1);
    endtask

    initial begin
        vec_t v;
        // single response
        v = '0; v.pc = 1; v.r[0] = 19'h00001; v.golden = 19'h00001;
        v.exp_sig = 19'h00001; v.exp_pass = 1'b1; tbl[0] = v;
        // feedback path, matching and mismatching golden
        v = '0; v.pc = 2; v.r[0] = 19'h40000; v.r[1] = 19'h00000; v.golden = 19'h00027;
        v.exp_sig = 19'h00027; v.exp_pass = 1'b1; tbl[1] = v;
        v.golden = 19'h00026; v.exp_pass = 1'b0; tbl[2] = v;
        // stalls: 1 -> 2^2=0 -> 0^4=4
        v = '0; v.pc = 3; v.r[0] = 19'h1; v.r[1] = 19'h2; v.r[2] = 19'h4;
        v.gap[0] = 0; v.gap[1] = 2; v.gap[2] = 5;
        v.golden = 19'h00004; v.exp_sig = 19'h00004; v.exp_pass = 1'b1; tbl[3] = v;
        // zero count compares SEED
        v = '0; v.pc = 0; v.golden = 19'h0; v.exp_sig = 19'h0; v.exp_pass = 1'b1; tbl[4] = v;
        // mixed data, golden from the bench model
        v = '0; v.pc = 4; v.r[0] = 19'h12345; v.r[1] = 19'h7FFFF; v.r[2] = 19'h00ABC;
        v.r[3] = 19'h55555; v.gap[2] = 1;
        v.exp_sig = model_sig(v); v.golden = v.exp_sig; v.exp_pass = 1'b1; tbl[5] = v;
        n_vec = 6;
`ifdef S832_MISR_XMASK_EN
        v = '0; v.pc = 4; v.mask = 19'h7FFFF;
        for (int i = 0; i < 4; i++) v.r[i] = 19'h7FFFF;
        v.golden = 19'h0; v.exp_sig = 19'h0; v.exp_pass = 1'b1; tbl[6] = v;
        n_vec = 7;
`endif

        // reset state
        #12;
        chk("rst_sig", {13'd0, signature}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        @(negedge CK);
        RN = 1'b1;

        for (int k = 0; k < n_vec; k++) run_vec(tbl[k], k);

        // start while busy is ignored
        @(negedge CK);
        start = 1'b1; pat_count = 16'd2; golden = step(step('0, 19'h00003), 19'h00100);
        @(negedge CK); start = 1'b0;
        @(negedge CK);
        start = 1'b1; pat_count = 16'd7; resp = 19'h00003; resp_valid = 1'b1;
        @(negedge CK);
        start = 1'b0; resp = 19'h00100;
        @(negedge CK);
        resp_valid = 1'b0;
        chk("ign_start_sig", {13'd0, signature}, {13'd0, golden});
        @(negedge CK);
        chk("ign_start_done", {31'd0, done}, 32'd1);
        chk("ign_start_pass", {31'd0, pass}, 32'd1);

        // reset mid-run after 3 of 10 responses, then a clean rerun
        v = '0; v.pc = 10;
        for (int i = 0; i < 10; i++) v.r[i] = W'(32'h1F0F3 * (i + 1));
        v.exp_sig = model_sig(v); v.golden = v.exp_sig; v.exp_pass = 1'b1;
        @(negedge CK);
        start = 1'b1; pat_count = 16'd10;
        @(negedge CK); start = 1'b0;
        @(negedge CK);
        for (int i = 0; i < 3; i++) begin
            resp = v.r[i]; resp_valid = 1'b1;
            @(negedge CK);
        end
        resp_valid = 1'b0;
        #2 RN = 1'b0;
        #1;
        chk("mid_rst_sig", {13'd0, signature}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        @(negedge CK);
        RN = 1'b1;
        run_vec(v, 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
